ttt_referee: RTL and testbench
==============================

// Module: ttt_referee
// PURPOSE
//  Move arbiter and board keeper for tic-tac-toe: accepts keypad moves (player 1) and
//  moves from the AI player or a second human (player 2), validates them, maintains both
//  boards, enforces turn order and declares win/draw. It sits between the keypad debouncer
//  and the AI player and display logic. It consumes key_flag_AI/key_value_AI from the AI and
//  drives chessboard_human, the accepted-move pulse that the AI uses as key_flag, and over.
// PARAMETERS
//  AI_TIMEOUT  16  cycles allowed from p1_move_flag to an AI move before ai_fault is raised
// PORTS
//  clk             in   1  system clock
//  reset_n         in   1  asynchronous, active-low reset
//  mode_switch     in   1  1 = human vs AI, 0 = human vs human
//  new_game        in   1  1-cycle pulse: clear boards, start a new game
//  key_flag        in   1  1-cycle pulse: keypad move valid
//  key_value       in   4  keypad position 1..9 (row-major, 1 = top-left)
//  key_flag_AI     in   1  1-cycle pulse: AI move valid
//  key_value_AI    in   4  AI position 1..9
//  chessboard_human out 9  player-1 stones; position k maps to bit 9-k
//  chessboard_p2   out  9  player-2/AI stones, same mapping
//  p1_move_flag    out  1  1-cycle pulse, high in the cycle after a player-1 move is accepted (drives the AI key_flag)
//  turn            out  1  0 = player 1 to move, 1 = player 2/AI to move
//  over            out  1  game finished; held until new_game, mode change or reset
//  winner          out  2  00 none, 01 player 1, 10 player 2/AI, 11 draw
//  win_line        out  8  completed lines: rows[7:5], columns[4:2], diagonal[1], anti-diagonal[0]
//  illegal_move    out  1  1-cycle pulse, rejected move
//  ai_fault        out  1  sticky: AI missed AI_TIMEOUT or played an illegal move
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = P1_TURN, move_cnt = 0, watchdog = 0.
//  - FSM states: P1_TURN, P2_TURN, CHECK, OVER.
//  - A move is legal when:
//      - position is 1..9,
//      - the target bit is clear in both boards,
//      - it is the mover's turn,
//      - the FSM is not in CHECK or OVER.
//  - P1_TURN:
//      - A legal key_flag sets the bit at edge E; the board is visible after E.
//      - p1_move_flag is high for the cycle after E.
//      - FSM goes to CHECK with next turn = P2.
//  - P2_TURN:
//      - AI mode: only key_flag_AI is a move source. key_flag sets illegal_move only.
//      - HvH mode: only key_flag is a move source. key_flag_AI is ignored.
//      - A legal move sets the bit in chessboard_p2, then FSM goes to CHECK with next turn = P1.
//  - CHECK (exactly 1 cycle):
//      - Line check uses the registered boards. over, winner and win_line are registered at edge E+1.
//      - Player-1 line -> OVER, winner 01. Player-2 line -> OVER, winner 10.
//      - move_cnt == 9 with no line -> OVER, winner 11.
//      - Otherwise go to the next turn. turn updates at the same edge.
//  - Timing guarantee: over is valid no later than 2 cycles after p1_move_flag.
//  - OVER: all moves are ignored with no illegal_move pulse; outputs hold.
//  - Illegal move: the board is unchanged and illegal_move pulses 1 cycle. An illegal AI move also sets ai_fault.
//  - Watchdog (AI mode, P2_TURN only):
//      - Counts cycles and clears on leaving P2_TURN.
//      - At AI_TIMEOUT: set ai_fault, force OVER, winner 01.
//  - Simultaneous events:
//      - new_game has the highest priority: clear both boards, move_cnt, over, winner, win_line and ai_fault; go to P1_TURN.
//      - A mode_switch change (edge-detected with a registered copy) acts as new_game.
//      - key_flag and key_flag_AI in the same cycle: only the current mover's source is considered.
//  - Arithmetic: move_cnt is 4 bits and saturates at 9. Out-of-range key_value (0, 10..15) is illegal and never indexes a board bit.
// STRUCTURE
//  - Package tictactoe_pkg:
//      - state enum,
//      - WIN_LINES[8] 9-bit masks,
//      - winner codes (W_NONE, W_P1, W_P2, W_DRAW),
//      - function pos2bit(k) = 9-k.
//  - Sub-module ttt_line_checker: combinational, board[8:0] -> any_line, line_mask[7:0]. Instantiated once per board.
// TESTING
//  - Reset, then keys 1,2 (HvH), 4,5, 7 -> board_human 9'b100_100_100 after key 7; over = 1 one cycle later; winner 01; win_line 8'b0001_0000.
//  - Key 5 placed twice -> second pulse gives illegal_move = 1 for 1 cycle; turn and board unchanged.
//  - Key 0 or key 12 -> illegal_move pulse; board stays 0.
//  - Draw (HvH) sequence 1,2,3,5,4,6,8,7,9 -> over = 1; winner 11; win_line 0.
//  - AI mode: key 1 -> p1_move_flag, turn = 1; key_flag_AI with value 5 after 3 cycles -> chessboard_p2 = 9'b000_010_000, turn = 0. Same sequence with AI_TIMEOUT = 16 and no AI response -> ai_fault = 1, over = 1, winner 01 after 16 cycles.
//  - Mid-game: new_game together with key_flag, then toggle mode_switch -> both boards 0, turn 0, over 0, ai_fault 0.

Source files
------------

// File: rtl/ttt_referee_pkg.sv
`default_nettype none
// ============================================================================
// Module : tictactoe_pkg
// Brief  : Shared types, win-line masks and winner codes for the referee.
// Rev    : 1.0  initial release
// ============================================================================
package tictactoe_pkg;

    typedef enum logic [1:0] {
        P1_TURN = 2'd0,
        P2_TURN = 2'd1,
        CHECK   = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    // Index i is win_line bit i: rows 7..5, columns 4..2, diagonal 1, anti-diagonal 0.
    localparam logic [7:0][8:0] WIN_LINES = {
        9'b111_000_000, 9'b000_111_000, 9'b000_000_111,
        9'b100_100_100, 9'b010_010_010, 9'b001_001_001,
        9'b100_010_001, 9'b001_010_100
    };

    function automatic logic [3:0] pos2bit(input logic [3:0] k);
        return 4'd9 - k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_referee_if.sv
`default_nettype none
// ============================================================================
// Module : ttt_referee_if
// Brief  : Move inputs and board/result outputs of the tic-tac-toe referee.
// Rev    : 1.0  initial release
// ============================================================================
interface ttt_referee_if;
    logic       mode_switch;
    logic       new_game;
    logic       key_flag;
    logic [3:0] key_value;
    logic       key_flag_AI;
    logic [3:0] key_value_AI;
    logic [8:0] chessboard_human;
    logic [8:0] chessboard_p2;
    logic       p1_move_flag;
    logic       turn;
    logic       over;
    logic [1:0] winner;
    logic [7:0] win_line;
    logic       illegal_move;
    logic       ai_fault;

    modport master (
        output mode_switch, new_game, key_flag, key_value, key_flag_AI, key_value_AI,
        input  chessboard_human, chessboard_p2, p1_move_flag, turn, over, winner,
               win_line, illegal_move, ai_fault
    );

    modport slave (
        input  mode_switch, new_game, key_flag, key_value, key_flag_AI, key_value_AI,
        output chessboard_human, chessboard_p2, p1_move_flag, turn, over, winner,
               win_line, illegal_move, ai_fault
    );
endinterface
`default_nettype wire

// File: rtl/ttt_referee_line_checker.sv
`default_nettype none
// ============================================================================
// Module : ttt_line_checker
// Brief  : Combinational detection of completed lines on one 3x3 board.
// Rev    : 1.0  initial release
// ============================================================================
module ttt_line_checker
    import tictactoe_pkg::*;
(
    input  logic [8:0] board,
    output logic       any_line,
    output logic [7:0] line_mask
);
    for (genvar i = 0; i < 8; i++) begin : g_line
        assign line_mask[i] = &(board | ~WIN_LINES[i]);
    end

    assign any_line = |line_mask;
endmodule
`default_nettype wire

// File: rtl/ttt_referee.sv
`default_nettype none
// ============================================================================
// Module : ttt_referee
// Brief  : Validates moves, keeps both boards, enforces turns, declares results.
// Rev    : 1.0  initial release
// ============================================================================
module ttt_referee
    import tictactoe_pkg::*;
#(
    parameter int AI_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    ttt_referee_if.slave bus
);
    localparam int WD_W = $clog2(AI_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [8:0]      human_q, human_d, p2_q, p2_d;
    logic [3:0]      move_cnt_q, move_cnt_d;
    logic            turn_q, turn_d, over_q, over_d;
    logic [1:0]      winner_q, winner_d;
    logic [7:0]      win_line_q, win_line_d;
    logic            p1_flag_q, p1_flag_d, illegal_q, illegal_d;
    logic            fault_q, fault_d, mode_q, mode_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    logic       w_restart, w_key_range, w_ai_range, w_key_ok, w_ai_ok;
    logic       w_p1_line, w_p2_line;
    logic [7:0] w_p1_mask, w_p2_mask;
    logic [8:0] w_occupied, w_key_mask, w_ai_mask;
    logic [3:0] w_cnt_inc;

    ttt_line_checker u_p1_lines (.board(human_q), .any_line(w_p1_line), .line_mask(w_p1_mask));
    ttt_line_checker u_p2_lines (.board(p2_q),    .any_line(w_p2_line), .line_mask(w_p2_mask));

    assign w_restart   = bus.new_game || (bus.mode_switch != mode_q);
    assign w_occupied  = human_q | p2_q;
    // Out-of-range positions yield an empty mask so they never touch a board bit.
    assign w_key_range = (bus.key_value >= 4'd1) && (bus.key_value <= 4'd9);
    assign w_ai_range  = (bus.key_value_AI >= 4'd1) && (bus.key_value_AI <= 4'd9);
    assign w_key_mask  = w_key_range ? (9'd1 << pos2bit(bus.key_value)) : 9'd0;
    assign w_ai_mask   = w_ai_range ? (9'd1 << pos2bit(bus.key_value_AI)) : 9'd0;
    assign w_key_ok    = w_key_range && ((w_key_mask & w_occupied) == 9'd0);
    assign w_ai_ok     = w_ai_range && ((w_ai_mask & w_occupied) == 9'd0);
    assign w_cnt_inc   = (move_cnt_q == MAX_MOVES) ? move_cnt_q : move_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        human_d    = human_q;
        p2_d       = p2_q;
        move_cnt_d = move_cnt_q;
        turn_d     = turn_q;
        over_d     = over_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        fault_d    = fault_q;
        p1_flag_d  = 1'b0;
        illegal_d  = 1'b0;
        mode_d     = bus.mode_switch;
        wdog_d     = '0;

        if (w_restart) begin
            state_d    = P1_TURN;
            human_d    = '0;
            p2_d       = '0;
            move_cnt_d = '0;
            turn_d     = 1'b0;
            over_d     = 1'b0;
            winner_d   = W_NONE;
            win_line_d = '0;
            fault_d    = 1'b0;
        end else begin
            unique case (state_q)
                P1_TURN: begin
                    if (bus.key_flag) begin
                        if (w_key_ok) begin
                            human_d    = human_q | w_key_mask;
                            move_cnt_d = w_cnt_inc;
                            p1_flag_d  = 1'b1;
                            state_d    = CHECK;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                P2_TURN: begin
                    if (mode_q) begin
                        wdog_d = wdog_q + 1'b1;
                        if (bus.key_flag_AI && w_ai_ok) begin
                            p2_d       = p2_q | w_ai_mask;
                            move_cnt_d = w_cnt_inc;
                            state_d    = CHECK;
                            wdog_d     = '0;
                        end else begin
                            if (bus.key_flag_AI) begin
                                illegal_d = 1'b1;
                                fault_d   = 1'b1;
                            end else if (bus.key_flag) begin
                                illegal_d = 1'b1;
                            end
                            if (wdog_q == WD_W'(AI_TIMEOUT - 1)) begin
                                fault_d    = 1'b1;
                                over_d     = 1'b1;
                                winner_d   = W_P1;
                                win_line_d = '0;
                                state_d    = OVER;
                                wdog_d     = '0;
                            end
                        end
                    end else if (bus.key_flag) begin
                        if (w_key_ok) begin
                            p2_d       = p2_q | w_key_mask;
                            move_cnt_d = w_cnt_inc;
                            state_d    = CHECK;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (w_p1_line) begin
                        over_d     = 1'b1;
                        winner_d   = W_P1;
                        win_line_d = w_p1_mask;
                        state_d    = OVER;
                    end else if (w_p2_line) begin
                        over_d     = 1'b1;
                        winner_d   = W_P2;
                        win_line_d = w_p2_mask;
                        state_d    = OVER;
                    end else if (move_cnt_q == MAX_MOVES) begin
                        over_d     = 1'b1;
                        winner_d   = W_DRAW;
                        win_line_d = '0;
                        state_d    = OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = turn_q ? P1_TURN : P2_TURN;
                        // The AI allowance runs from p1_move_flag, so this CHECK cycle already counts.
                        wdog_d  = (!turn_q && mode_q) ? WD_W'(1) : '0;
                    end
                end
                OVER: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= P1_TURN;
            human_q    <= '0;
            p2_q       <= '0;
            move_cnt_q <= '0;
            turn_q     <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= W_NONE;
            win_line_q <= '0;
            fault_q    <= 1'b0;
            p1_flag_q  <= 1'b0;
            illegal_q  <= 1'b0;
            mode_q     <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            human_q    <= human_d;
            p2_q       <= p2_d;
            move_cnt_q <= move_cnt_d;
            turn_q     <= turn_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            fault_q    <= fault_d;
            p1_flag_q  <= p1_flag_d;
            illegal_q  <= illegal_d;
            mode_q     <= mode_d;
            wdog_q     <= wdog_d;
        end
    end

    assign bus.chessboard_human = human_q;
    assign bus.chessboard_p2    = p2_q;
    assign bus.p1_move_flag     = p1_flag_q;
    assign bus.turn             = turn_q;
    assign bus.over             = over_q;
    assign bus.winner           = winner_q;
    assign bus.win_line         = win_line_q;
    assign bus.illegal_move     = illegal_q;
    assign bus.ai_fault         = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_ttt_referee.sv
`default_nettype none
// ============================================================================
// Module : tb_ttt_referee
// Brief  : Scoreboard bench: directed moves push expected events, a monitor checks them.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ttt_referee;
    import tictactoe_pkg::*;

    typedef enum logic [2:0] {EV_P1, EV_ILL, EV_OVER, EV_TURN, EV_PROBE} ev_t;
    typedef enum logic [2:0] {O_ACC, O_ILL, O_ILLF, O_WIN, O_DRAW, O_IGN} oc_t;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] p2;
        logic       turn;
        logic       over;
        logic [1:0] winner;
        logic [7:0] wl;
        logic       fault;
    } snap_t;

    typedef struct {
        ev_t   kind;
        snap_t s;
        int    lat;
        logic  from_turn;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    logic  tb_probe = 1'b0;
    exp_t  q[$];
    snap_t e = '0;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    p1_cyc = 0;
    int    turn_cyc = 0;
    logic  prev_turn = 1'b0;
    logic  prev_over = 1'b0;

    always #5 clk = ~clk;

    ttt_referee_if bus();

    ttt_referee #(.AI_TIMEOUT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_ev(input ev_t k, input snap_t a);
        exp_t x;
        int   lat_act;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s act=%h req=none", k.name(), a);
            return;
        end
        x = q.pop_front();
        if (x.kind != k) begin
            bad++;
            $display("FAIL event_order act=%s req=%s", k.name(), x.kind.name());
            return;
        end
        if (a !== x.s) begin
            bad++;
            $display("FAIL %s_snapshot act=%h req=%h", k.name(), a, x.s);
        end
        if (x.lat != 0) begin
            total++;
            lat_act = cyc - (x.from_turn ? turn_cyc : p1_cyc);
            if (lat_act != x.lat) begin
                bad++;
                $display("FAIL %s_latency act=%0d req=%0d", k.name(), lat_act, x.lat);
            end
        end
    endtask

    // Monitor: every DUT-presented event is checked against the queue head.
    always @(negedge clk) begin
        snap_t a;
        a.h      = bus.chessboard_human;
        a.p2     = bus.chessboard_p2;
        a.turn   = bus.turn;
        a.over   = bus.over;
        a.winner = bus.winner;
        a.wl     = bus.win_line;
        a.fault  = bus.ai_fault;
        if (reset_n) begin
            if (bus.p1_move_flag)          check_ev(EV_P1, a);
            if (bus.illegal_move)          check_ev(EV_ILL, a);
            if (bus.over && !prev_over)    check_ev(EV_OVER, a);
            if (bus.turn != prev_turn)     check_ev(EV_TURN, a);
            if (tb_probe)                  check_ev(EV_PROBE, a);
            if (bus.p1_move_flag)          p1_cyc = cyc;
            if (bus.turn != prev_turn)     turn_cyc = cyc;
        end
        prev_turn = bus.turn;
        prev_over = bus.over;
        cyc++;
    end

    task automatic push(input ev_t k, input int lat, input logic from_turn);
        exp_t x;
        x.kind = k;
        x.s = e;
        x.lat = lat;
        x.from_turn = from_turn;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe();
        push(EV_PROBE, 0, 1'b0);
        @(posedge clk); #1;
        tb_probe = 1'b1;
        @(posedge clk); #1;
        tb_probe = 1'b0;
    endtask

    task automatic mv(input logic ai, input logic [3:0] pos, input oc_t oc, input logic [7:0] wl);
        case (oc)
            O_IGN: ;
            O_ILL, O_ILLF: begin
                if (oc == O_ILLF) e.fault = 1'b1;
                push(EV_ILL, 0, 1'b0);
            end
            default: begin
                if (e.turn == 1'b0) e.h[9 - pos] = 1'b1;
                else                e.p2[9 - pos] = 1'b1;
                if (e.turn == 1'b0) push(EV_P1, 0, 1'b0);
                if (oc == O_ACC) begin
                    e.turn = ~e.turn;
                    push(EV_TURN, 0, 1'b0);
                end else begin
                    e.over   = 1'b1;
                    e.winner = (oc == O_DRAW) ? W_DRAW : (e.turn ? W_P2 : W_P1);
                    e.wl     = wl;
                    push(EV_OVER, (e.turn == 1'b0) ? 1 : 0, 1'b0);
                end
            end
        endcase
        @(posedge clk); #1;
        if (ai) begin
            bus.key_flag_AI = 1'b1;
            bus.key_value_AI = pos;
        end else begin
            bus.key_flag = 1'b1;
            bus.key_value = pos;
        end
        @(posedge clk); #1;
        bus.key_flag = 1'b0;
        bus.key_flag_AI = 1'b0;
        idle(4);
    endtask

    task automatic restart(input logic toggle, input logic with_key);
        logic was_turn;
        was_turn = e.turn;
        e = '0;
        if (was_turn) push(EV_TURN, 0, 1'b0);
        @(posedge clk); #1;
        if (toggle) bus.mode_switch = ~bus.mode_switch;
        else        bus.new_game = 1'b1;
        if (with_key) begin
            bus.key_flag = 1'b1;
            bus.key_value = 4'd2;
        end
        @(posedge clk); #1;
        bus.new_game = 1'b0;
        bus.key_flag = 1'b0;
        idle(2);
        probe();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        bus.mode_switch = 1'b0;
        bus.new_game = 1'b0;
        bus.key_flag = 1'b0;
        bus.key_value = 4'd0;
        bus.key_flag_AI = 1'b0;
        bus.key_value_AI = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        probe();

        // HvH: player 1 completes the left column.
        mv(0, 4'd1, O_ACC, 8'h00);
        mv(0, 4'd2, O_ACC, 8'h00);
        mv(0, 4'd4, O_ACC, 8'h00);
        mv(0, 4'd5, O_ACC, 8'h00);
        mv(0, 4'd7, O_WIN, 8'b0001_0000);
        mv(0, 4'd3, O_IGN, 8'h00);
        mv(0, 4'd8, O_IGN, 8'h00);
        probe();

        // Occupied and out-of-range positions.
        restart(0, 0);
        mv(0, 4'd5,  O_ACC, 8'h00);
        mv(0, 4'd5,  O_ILL, 8'h00);
        mv(0, 4'd0,  O_ILL, 8'h00);
        mv(0, 4'd12, O_ILL, 8'h00);
        mv(1, 4'd3,  O_IGN, 8'h00);
        mv(0, 4'd1,  O_ACC, 8'h00);
        mv(0, 4'd0,  O_ILL, 8'h00);
        mv(0, 4'd12, O_ILL, 8'h00);
        probe();

        // Draw.
        restart(0, 0);
        mv(0, 4'd1, O_ACC, 8'h00);
        mv(0, 4'd2, O_ACC, 8'h00);
        mv(0, 4'd3, O_ACC, 8'h00);
        mv(0, 4'd5, O_ACC, 8'h00);
        mv(0, 4'd4, O_ACC, 8'h00);
        mv(0, 4'd6, O_ACC, 8'h00);
        mv(0, 4'd8, O_ACC, 8'h00);
        mv(0, 4'd7, O_ACC, 8'h00);
        mv(0, 4'd9, O_DRAW, 8'h00);

        // Player 2 takes the anti-diagonal.
        restart(0, 0);
        mv(0, 4'd1, O_ACC, 8'h00);
        mv(0, 4'd5, O_ACC, 8'h00);
        mv(0, 4'd2, O_ACC, 8'h00);
        mv(0, 4'd3, O_ACC, 8'h00);
        mv(0, 4'd4, O_ACC, 8'h00);
        mv(0, 4'd7, O_WIN, 8'b0000_0001);
        restart(0, 0);

        // AI mode.
        restart(1, 0);
        mv(0, 4'd1, O_ACC, 8'h00);
        mv(0, 4'd9, O_ILL, 8'h00);
        mv(1, 4'd5, O_ACC, 8'h00);
        mv(1, 4'd9, O_IGN, 8'h00);
        mv(0, 4'd9, O_ACC, 8'h00);
        mv(1, 4'd1, O_ILLF, 8'h00);
        mv(1, 4'd3, O_ACC, 8'h00);
        probe();

        // AI never answers: watchdog forfeits the game to player 1.
        restart(0, 0);
        mv(0, 4'd1, O_ACC, 8'h00);
        idle(3);
        probe();
        e.over = 1'b1;
        e.winner = W_P1;
        e.wl = 8'h00;
        e.fault = 1'b1;
        push(EV_OVER, 16, 1'b0);
        for (int i = 0; i < 40 && !bus.over; i++) @(posedge clk);
        #1;
        if (!bus.over) begin
            total++;
            bad++;
            $display("FAIL watchdog_wait act=over0 req=over1");
        end
        idle(2);

        // Restarts mid-game: new_game beats a same-cycle key, then a mode change.
        restart(0, 0);
        mv(0, 4'd1, O_ACC, 8'h00);
        mv(1, 4'd5, O_ACC, 8'h00);
        restart(0, 1);
        mv(0, 4'd4, O_ACC, 8'h00);
        restart(1, 0);

        idle(3);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_events act=%0d req=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
